// File: rtl/data_register_file.sv
// Bank of NREGS data registers loaded IW bits at a time, with clear, extend-load,
// shift-insert, increment/decrement, two combinational read ports and per-register fill flags.
module data_register_file #(
  parameter int WIDTH = 32,
  parameter int IW    = 8,
  parameter int NREGS = 4,
  parameter int SW    = $clog2(NREGS),
  parameter int K     = WIDTH / IW
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [IW-1:0]    I,
  input  logic [2:0]       FunSel,
  input  logic [NREGS-1:0] RegSel,
  input  logic [SW-1:0]    OutCSel,
  input  logic [SW-1:0]    OutDSel,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic [NREGS-1:0] Full
);

  localparam int FW = $clog2(K + 1);
  localparam logic [FW-1:0] K_F = FW'(K);

  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_LDS   = 3'b001;
  localparam logic [2:0] OP_LDZ   = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;

  logic [WIDTH-1:0] reg_val [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] r_q, r_d;
      logic [FW-1:0]    f_q, f_d;
      logic [FW-1:0]    f_sat;

      // Shift-inserts count chunks but never past K, so the register stays "full".
      assign f_sat = (f_q == K_F) ? K_F : f_q + FW'(1);

      always_comb begin
        r_d = r_q;
        f_d = f_q;
        if (RegSel[gi]) begin
          unique case (FunSel)
            OP_CLR: begin
              r_d = '0;
              f_d = '0;
            end
            OP_LDS: begin
              r_d = {{(WIDTH-IW){I[IW-1]}}, I};
              f_d = FW'(1);
            end
            OP_LDZ: begin
              r_d = {{(WIDTH-IW){1'b0}}, I};
              f_d = FW'(1);
            end
            OP_SHL: begin
              r_d = {r_q[WIDTH-IW-1:0], I};
              f_d = f_sat;
            end
            OP_SHR: begin
              r_d = {I, r_q[WIDTH-1:IW]};
              f_d = f_sat;
            end
            OP_INC:  r_d = r_q + WIDTH'(1);
            OP_DEC:  r_d = r_q - WIDTH'(1);
            default: ;
          endcase
        end
      end

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_q <= '0;
          f_q <= '0;
        end else begin
          r_q <= r_d;
          f_q <= f_d;
        end
      end

      assign reg_val[gi] = r_q;
      assign Full[gi]    = (f_q == K_F);
    end
  endgenerate

  // Selects past the last register (non power-of-two banks) read as zero.
  always_comb begin
    OutC = '0;
    OutD = '0;
    if (int'(OutCSel) < NREGS) OutC = reg_val[OutCSel];
    if (int'(OutDSel) < NREGS) OutD = reg_val[OutDSel];
  end

endmodule

// File: tb/tb_data_register_file.sv
// Randomized and directed checks of data_register_file against a behavioural
// model of the register bank kept as plain arrays.
module tb_data_register_file;

  localparam int WIDTH = 32;
  localparam int IW    = 8;
  localparam int NREGS = 4;
  localparam int SW    = 2;
  localparam int K     = 4;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [IW-1:0]    I;
  logic [2:0]       FunSel;
  logic [NREGS-1:0] RegSel;
  logic [SW-1:0]    OutCSel;
  logic [SW-1:0]    OutDSel;
  logic [WIDTH-1:0] OutC;
  logic [WIDTH-1:0] OutD;
  logic [NREGS-1:0] Full;

  data_register_file #(.WIDTH(WIDTH), .IW(IW), .NREGS(NREGS)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .OutCSel (OutCSel),
    .OutDSel (OutDSel),
    .OutC    (OutC),
    .OutD    (OutD),
    .Full    (Full)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents and number of chunks assembled.
  logic [31:0] m_reg [NREGS];
  int          m_cnt [NREGS];

  function automatic logic [NREGS-1:0] exp_full();
    logic [NREGS-1:0] f;
    for (int r = 0; r < NREGS; r++) f[r] = (m_cnt[r] == K);
    return f;
  endfunction

  function automatic void model_update(input logic [2:0] op, input logic [3:0] sel,
                                       input logic [7:0] din, input logic rst);
    logic [31:0] ext;
    ext = {24'd0, din};
    for (int r = 0; r < NREGS; r++) begin
      if (rst) begin
        m_reg[r] = 0;
        m_cnt[r] = 0;
      end else if (sel[r]) begin
        case (op)
          3'd0: begin m_reg[r] = 0; m_cnt[r] = 0; end
          3'd1: begin m_reg[r] = (din >= 8'd128) ? (ext + 32'hFFFFFF00) : ext; m_cnt[r] = 1; end
          3'd2: begin m_reg[r] = ext; m_cnt[r] = 1; end
          3'd3: begin
            m_reg[r] = m_reg[r] * 256 + ext;
            m_cnt[r] = (m_cnt[r] + 1 > K) ? K : m_cnt[r] + 1;
          end
          3'd4: begin
            m_reg[r] = m_reg[r] / 256 + ext * 32'h0100_0000;
            m_cnt[r] = (m_cnt[r] + 1 > K) ? K : m_cnt[r] + 1;
          end
          3'd5: m_reg[r] = m_reg[r] + 1;
          3'd6: m_reg[r] = m_reg[r] - 1;
          default: ;
        endcase
      end
    end
  endfunction

  task automatic setup(input logic [2:0] op, input logic [3:0] sel,
                       input logic [7:0] din, input logic rst);
    @(negedge Clock);
    FunSel = op;
    RegSel = sel;
    I      = din;
    Reset  = rst;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_update(FunSel, RegSel, I, Reset);
    #1;
    Reset  = 1'b0;
    RegSel = '0;
    FunSel = 3'b111;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] sel,
                       input logic [7:0] din, input logic rst);
    setup(op, sel, din, rst);
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      logic [31:0] pat;
      pat = 32'hDEADBEEF;
      drive(3'd3, 4'b1111, pat[31-8*c -: 8], 1'b0);
    end
    for (int r = 0; r < NREGS; r++) begin
      OutCSel = SW'(r); OutDSel = SW'(NREGS - 1 - r); #1;
      checks++;
      if (OutC !== 32'hDEADBEEF) begin
        errors++; $display("FAIL preload R%0d: got %h expected deadbeef", r, OutC);
      end
    end
    drive(3'd3, 4'b1111, 8'h77, 1'b1);
    for (int r = 0; r < NREGS; r++) begin
      OutCSel = SW'(r); OutDSel = SW'((r + 1) % NREGS); #1;
      checks++;
      if (OutC !== 32'h0 || OutD !== 32'h0) begin
        errors++; $display("FAIL reset_out sel%0d: got C=%h D=%h expected 0", r, OutC, OutD);
      end
    end
    checks++;
    if (Full !== 4'b0000) begin
      errors++; $display("FAIL reset_full: got %b expected 0000", Full);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_ext();
    OutCSel = 0; OutDSel = 0;
    drive(3'd1, 4'b0001, 8'h80, 1'b0);
    checks++;
    if (OutC !== 32'hFFFFFF80) begin
      errors++; $display("FAIL load_sext: got %h expected ffffff80", OutC);
    end
    drive(3'd3, 4'b0001, 8'h12, 1'b0);
    drive(3'd2, 4'b0001, 8'h80, 1'b0);
    checks++;
    if (OutD !== 32'h00000080 || OutD !== m_reg[0]) begin
      errors++; $display("FAIL load_zext: got %h expected 00000080", OutD);
    end
    checks++;
    if (Full !== exp_full()) begin
      errors++; $display("FAIL load_full: got %b expected %b", Full, exp_full());
    end
    $display("test_load_ext done R0=%h", OutC);
  endtask

  task automatic test_shift_left();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    OutCSel = 1; OutDSel = 1;
    drive(3'd0, 4'b0010, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(3'd3, 4'b0010, bytes[c], 1'b0);
      checks++;
      if (Full[1] !== (c >= 3)) begin
        errors++; $display("FAIL shl_full step%0d: got %b expected %b", c, Full[1], c >= 3);
      end
      if (c == 3) begin
        checks++;
        if (OutC !== 32'h11223344) begin
          errors++; $display("FAIL shl_assemble: got %h expected 11223344", OutC);
        end
      end
    end
    checks++;
    if (OutD !== 32'h22334455) begin
      errors++; $display("FAIL shl_saturate: got %h expected 22334455", OutD);
    end
    $display("test_shift_left done R1=%h", OutC);
  endtask

  task automatic test_shift_right();
    OutCSel = 2; OutDSel = 0;
    drive(3'd0, 4'b0100, 8'h00, 1'b0);
    drive(3'd4, 4'b0100, 8'hAA, 1'b0);
    drive(3'd4, 4'b0100, 8'hBB, 1'b0);
    checks++;
    if (OutC !== 32'hBBAA0000 || Full[2] !== 1'b0) begin
      errors++; $display("FAIL shr: got %h full=%b expected bbaa0000 full=0", OutC, Full[2]);
    end
    $display("test_shift_right done R2=%h", OutC);
  endtask

  task automatic test_wrap();
    OutCSel = 3; OutDSel = 3;
    for (int c = 0; c < 4; c++) drive(3'd3, 4'b1000, 8'hFF, 1'b0);
    drive(3'd5, 4'b1000, 8'h00, 1'b0);
    checks++;
    if (OutC !== 32'h0 || Full[3] !== 1'b1) begin
      errors++; $display("FAIL wrap_inc: got %h full=%b expected 00000000 full=1", OutC, Full[3]);
    end
    drive(3'd6, 4'b1000, 8'h00, 1'b0);
    checks++;
    if (OutD !== 32'hFFFFFFFF || Full[3] !== 1'b1) begin
      errors++; $display("FAIL wrap_dec: got %h full=%b expected ffffffff full=1", OutD, Full[3]);
    end
    $display("test_wrap done R3=%h", OutC);
  endtask

  task automatic test_multi_reset();
    drive(3'd2, 4'b0100, 8'h05, 1'b0);
    OutCSel = 2; OutDSel = 2;
    setup(3'd3, 4'b1111, 8'h01, 1'b0);
    #1;
    checks++;
    if (OutC !== 32'h5 || OutD !== 32'h5) begin
      errors++; $display("FAIL no_bypass: got C=%h D=%h expected 00000005", OutC, OutD);
    end
    tick();
    drive(3'd3, 4'b1111, 8'h01, 1'b0);
    for (int r = 0; r < NREGS; r++) begin
      OutCSel = SW'(r); #1;
      checks++;
      if (OutC !== m_reg[r]) begin
        errors++; $display("FAIL multi_shl R%0d: got %h expected %h", r, OutC, m_reg[r]);
      end
    end
    drive(3'd3, 4'b1111, 8'h01, 1'b1);
    for (int r = 0; r < NREGS; r++) begin
      OutCSel = SW'(r); OutDSel = SW'(r); #1;
      checks++;
      if (OutC !== 32'h0 || OutD !== 32'h0) begin
        errors++; $display("FAIL multi_reset R%0d: got C=%h D=%h expected 0", r, OutC, OutD);
      end
    end
    checks++;
    if (Full !== 4'b0000) begin
      errors++; $display("FAIL multi_reset_full: got %b expected 0000", Full);
    end
    drive(3'd3, 4'b0001, 8'h09, 1'b0);
    OutCSel = 0; #1;
    checks++;
    if (OutC !== 32'h9 || Full !== 4'b0000) begin
      errors++; $display("FAIL post_reset_shift: got %h full=%b expected 00000009 full=0000", OutC, Full);
    end
    $display("test_multi_reset done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      logic [3:0] sel;
      logic       rst;
      op  = 3'($urandom_range(0, 7));
      sel = 4'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) sel = 4'b0000;
      drive(op, sel, 8'($urandom), rst);
      OutCSel = SW'($urandom); OutDSel = SW'($urandom); #1;
      checks++;
      if (OutC !== m_reg[OutCSel] || OutD !== m_reg[OutDSel] || Full !== exp_full()) begin
        errors++;
        $display("FAIL random n=%0d op=%0d sel=%b: got C=%h D=%h full=%b expected C=%h D=%h full=%b",
                 n, op, sel, OutC, OutD, Full, m_reg[OutCSel], m_reg[OutDSel], exp_full());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    Reset = 1'b1; I = '0; FunSel = 3'b111; RegSel = '0; OutCSel = '0; OutDSel = '0;
    for (int r = 0; r < NREGS; r++) begin m_reg[r] = 0; m_cnt[r] = 0; end
    @(posedge Clock); #1;
    Reset = 1'b0;
    test_reset();
    test_load_ext();
    test_shift_left();
    test_shift_right();
    test_wrap();
    test_multi_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_register_file.md
# data_register_file

Parametrised bank of NREGS data registers, each WIDTH bits, loaded IW bits at a time with sign-extend, zero-extend and byte-shift modes, plus clear, increment and decrement. It replaces single-register data-register instances in the datapath. Two independent read ports feed the ALU operand muxes. A per-register fill counter reports when a register has been fully assembled from serial byte loads.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of IW.
- IW, 8, input chunk width in bits.
- NREGS, 4, number of registers; must be at least 2.
- SW, $clog2(NREGS), read-select width (derived).
- K, WIDTH/IW, chunks per register (derived).

Ports:
- Clock, input, 1: the only clock; all state updates on its rising edge.
- Reset, input, 1: reset, synchronous and active-high; clears every register and every fill counter.
- I, input, IW: input chunk.
- FunSel, input, 3: operation applied to every selected register.
- RegSel, input, NREGS: write mask; bit r enables register r; multiple bits allowed.
- OutCSel, input, SW: read-port C register index.
- OutDSel, input, SW: read-port D register index.
- OutC, output, WIDTH: contents of register OutCSel.
- OutD, output, WIDTH: contents of register OutDSel.
- Full, output, NREGS: bit r is high when the fill count of register r equals K.

## Operation
- Each register R[r] has a fill counter F[r] of width $clog2(K+1).
- FunSel encoding, applied on a rising edge to every r with RegSel[r]=1:
  - 000 clear: R=0, F=0.
  - 001 load sign-extend: R={ (WIDTH-IW){I[IW-1]} , I }, F=1.
  - 010 load zero-extend: R={ (WIDTH-IW)'0 , I }, F=1.
  - 011 shift-left insert: R={ R[WIDTH-IW-1:0], I }, F=min(F+1,K).
  - 100 shift-right insert: R={ I, R[WIDTH-1:IW] }, F=min(F+1,K).
  - 101 increment: R=R+1 modulo 2^WIDTH; F unchanged.
  - 110 decrement: R=R-1 modulo 2^WIDTH; F unchanged.
  - 111 hold: no change.
- Registers with RegSel[r]=0 hold R and F.
- With RegSel all zero, nothing changes regardless of FunSel.
- Read ports are combinational muxes of the current register state. They do not bypass a same-cycle write.
- OutCSel and OutDSel may be equal; both ports then show the same register.
- An out-of-range select (index ≥ NREGS when NREGS is not a power of two) drives 0 on that port.
- Full[r] is a combinational decode of F[r]==K.
- Arithmetic is unsigned wrap-around. There is no carry or borrow output.

## Timing
- Reset: when Reset=1 on a rising edge, every R=0 and every F=0 on the next cycle. Reset overrides FunSel and RegSel.
  - After reset, OutC=0, OutD=0 and Full=0.
- Write latency is 1 cycle. A change to R or F is visible on OutC, OutD and Full immediately after the edge that performs it.
- Read latency is 0 cycles, combinational from the select inputs and register state.
- Shift saturation: once F=K, further shifts keep shifting data, and F stays at K.
- A load (001 or 010) after full assembly restarts the count at F=1.
- When Reset is asserted mid-assembly (F between 1 and K-1), both R and F return to 0. The next shift therefore begins a fresh count.
- A multi-register write applies the same operation to each selected register independently, using each register's own prior value.

## Test plan
- Reset with all registers preloaded to 0xDEADBEEF -> next cycle OutC=OutD=0 for every select, and Full=4'b0000.
- RegSel=0001, FunSel=001, I=0x80 -> R0=0xFFFFFF80. Then FunSel=010, I=0x80 -> R0=0x00000080, and F0 is 1 after each load.
- R1 cleared, then RegSel=0010 with FunSel=011 for 4 cycles, I=0x11,0x22,0x33,0x44 -> R1=0x11223344.
  - Full[1] rises only after the 4th edge.
  - A 5th shift with I=0x55 gives R1=0x22334455 with Full[1] still 1.
- Shift-right: R2 cleared, then FunSel=100 with I=0xAA then 0xBB -> R2=0xBBAA0000 and Full[2]=0.
- Wrap: R3=0xFFFFFFFF, FunSel=101 -> R3=0x00000000. Then FunSel=110 -> R3=0xFFFFFFFF. F3 is unchanged throughout.
- Multi-write plus reset mid-operation:
  - RegSel=1111, FunSel=011, I=0x01 for 2 cycles, Reset=1 on the 3rd cycle -> all registers 0 and Full=0.
  - On the same cycle, OutCSel=OutDSel=2 with R2 preloaded to 0x5 shows OutC=OutD=0x5 before the write edge.
